io_bus_arbiter: RTL

Two-master arbiter for the single 16-bit strobe/ack I/O bus. Master 0 is the CPU core; master 1 is the UART loader path in the periphery hub, which writes received words to memory and reads them back. The arbiter registers one master's request, drives it onto the shared slave port, returns the slave's acknowledge and read data to that master, and rotates priority between the masters. It sits between the two masters and the I/O decode/memory side at the top level.

---
 rtl/io_bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the 16-bit strobe/ack I/O bus.
// Optional slave timeout: define IO_ARB_TIMEOUT_EN (abort after TIMEOUT cycles without s_ack_i).
module io_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [15:0] m0_addr_i,
  input  logic [15:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [15:0] m0_dat_o,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [15:0] m1_addr_i,
  input  logic [15:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [15:0] m1_dat_o,
  output logic        err_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [15:0] s_addr_o,
  output logic [15:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [15:0] s_dat_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic        last;
  logic [15:0] rdata;

  // One read-data register serves both masters; only the ack qualifies it.
  assign m0_dat_o = rdata;
  assign m1_dat_o = rdata;

`ifdef IO_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;
  logic       timed_out;
  assign timed_out = (cnt == 8'(TIMEOUT));
  assign err_o     = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign err_o          = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      last     <= 1'b1;
      s_stb_o  <= 1'b0;
      s_we_o   <= 1'b0;
      s_addr_o <= 16'h0000;
      s_dat_o  <= 16'h0000;
      rdata    <= 16'h0000;
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      gnt_o    <= 2'b00;
`ifdef IO_ARB_TIMEOUT_EN
      cnt      <= 8'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // On a tie, last == 1 means master 1 was served last, so master 0 wins.
          if (m0_stb_i && (!m1_stb_i || last)) begin
            state    <= BUSY0;
            last     <= 1'b0;
            gnt_o    <= 2'b01;
            s_stb_o  <= 1'b1;
            s_we_o   <= m0_we_i;
            s_addr_o <= m0_addr_i;
            s_dat_o  <= m0_dat_i;
`ifdef IO_ARB_TIMEOUT_EN
            cnt      <= 8'd0;
`endif
          end else if (m1_stb_i) begin
            state    <= BUSY1;
            last     <= 1'b1;
            gnt_o    <= 2'b10;
            s_stb_o  <= 1'b1;
            s_we_o   <= m1_we_i;
            s_addr_o <= m1_addr_i;
            s_dat_o  <= m1_dat_i;
`ifdef IO_ARB_TIMEOUT_EN
            cnt      <= 8'd0;
`endif
          end
        end
        BUSY0, BUSY1: begin
          if (s_ack_i) begin
            rdata    <= s_dat_i;
            s_stb_o  <= 1'b0;
            state    <= DONE;
            m0_ack_o <= (state == BUSY0);
            m1_ack_o <= (state == BUSY1);
`ifdef IO_ARB_TIMEOUT_EN
          end else if (timed_out) begin
            rdata    <= 16'hFFFF;
            err_q    <= 1'b1;
            s_stb_o  <= 1'b0;
            state    <= DONE;
            m0_ack_o <= (state == BUSY0);
            m1_ack_o <= (state == BUSY1);
          end else begin
            cnt      <= cnt + 8'd1;
`endif
          end
        end
        DONE: begin
          // Strobes are not sampled here, so the served master cannot be re-granted.
          state <= IDLE;
          gnt_o <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
